// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the UART-datapath synchronous FIFO.
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN (sticky overflow/underflow).
package sync_fifo_pkg;

    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_ADDR_W   = 4;
    localparam int unsigned DEF_AF_LEVEL = (1 << DEF_ADDR_W) - 2;
    localparam int unsigned DEF_AE_LEVEL = 2;

    // Number of entries addressed by an addr_w-bit pointer.
    function automatic int unsigned fifo_depth(input int unsigned addr_w);
        return 32'(1) << addr_w;
    endfunction

endpackage : sync_fifo_pkg

// File: rtl/fifo_mem.sv
// Storage array for sync_fifo: one synchronous write port, one asynchronous read port.
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port; contents are never reset or cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Show-ahead read port.
    assign rdata = mem_q[raddr];

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count, almost flags and flush.
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN (sticky overflow/underflow).
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned AF_LEVEL = fifo_depth(ADDR_W) - 2,
    parameter int unsigned AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned   PTR_W  = ADDR_W + 1;
    localparam logic [ADDR_W:0] AF_CNT = PTR_W'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT = PTR_W'(AE_LEVEL);

    logic               rdy_q;
    logic [ADDR_W:0]    w_ptr_q, w_ptr_d;
    logic [ADDR_W:0]    r_ptr_q, r_ptr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               af_q, af_d;
    logic               ae_q, ae_d;
    logic               clr_ok;
    logic               push_ok;
    logic               pop_ok;

    // Reset release is taken one edge late so no operation races the async deassertion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // Pointer update and flag decode from the next pointer values.
    always_comb begin
        clr_ok  = rdy_q & clr;
        push_ok = rdy_q & push & ~full_q;
        pop_ok  = rdy_q & pop & ~empty_q;
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        if (clr_ok) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
        end else begin
            if (push_ok) w_ptr_d = w_ptr_q + PTR_W'(1);
            if (pop_ok)  r_ptr_d = r_ptr_q + PTR_W'(1);
        end
        count_d = w_ptr_d - r_ptr_d;
        empty_d = (w_ptr_d == r_ptr_d);
        full_d  = (w_ptr_d[ADDR_W] != r_ptr_d[ADDR_W]) &&
                  (w_ptr_d[ADDR_W-1:0] == r_ptr_d[ADDR_W-1:0]);
        af_d    = (count_d >= AF_CNT);
        ae_d    = (count_d <= AE_CNT);
    end

    // Pointer and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .wr_en (push_ok & ~clr_ok),
        .waddr (w_ptr_q[ADDR_W-1:0]),
        .wdata (push_data),
        .raddr (r_ptr_q[ADDR_W-1:0]),
        .rdata (pop_data)
    );

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // Sticky error flags; only flush or reset clears them.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (clr_ok) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            if (rdy_q && push && full_q)  ovf_d = 1'b1;
            if (rdy_q && pop && empty_q)  udf_d = 1'b1;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo with default parameters.
module tb_sync_fifo;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam logic [31:0] ERR_EN = 32'd1;
`else
    localparam logic [31:0] ERR_EN = 32'd0;
`endif

    logic       clk;
    logic       rst;
    logic       clr;
    logic       push;
    logic [7:0] push_data;
    logic       pop;
    logic [7:0] pop_data;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    sync_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .push         (push),
        .push_data    (push_data),
        .pop          (pop),
        .pop_data     (pop_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        clr       = 1'b0;
        push      = 1'b0;
        push_data = 8'h00;
        pop       = 1'b0;
        step();
        step();

        // Reset state
        check("rst_empty",  32'(empty), 32'd1);
        check("rst_full",   32'(full), 32'd0);
        check("rst_count",  32'(count), 32'd0);
        check("rst_ae",     32'(almost_empty), 32'd1);
        check("rst_af",     32'(almost_full), 32'd0);
        check("rst_ovf",    32'(overflow), 32'd0);
        check("rst_udf",    32'(underflow), 32'd0);

        // Release reset with a push pending: edge 1 ignored, edge 2 accepted
        rst       = 1'b1;
        push      = 1'b1;
        push_data = 8'h11;
        step();
        check("release_edge1_count", 32'(count), 32'd0);
        step();
        check("push1_count", 32'(count), 32'd1);
        check("push1_empty", 32'(empty), 32'd0);
        check("push1_data",  32'(pop_data), 32'h11);
        push_data = 8'h22;
        step();
        check("push2_count", 32'(count), 32'd2);
        check("push2_ae",    32'(almost_empty), 32'd1);
        push_data = 8'h33;
        step();
        check("push3_count", 32'(count), 32'd3);
        check("push3_ae",    32'(almost_empty), 32'd0);
        push = 1'b0;
        pop  = 1'b1;
        check("pop_head0", 32'(pop_data), 32'h11);
        step();
        check("pop1_count", 32'(count), 32'd2);
        check("pop1_data",  32'(pop_data), 32'h22);
        step();
        check("pop2_count", 32'(count), 32'd1);
        check("pop2_data",  32'(pop_data), 32'h33);
        step();
        check("pop3_count", 32'(count), 32'd0);
        check("pop3_empty", 32'(empty), 32'd1);

        // Pop on empty
        step();
        check("udf_flag",  32'(underflow), ERR_EN);
        check("udf_count", 32'(count), 32'd0);
        check("udf_empty", 32'(empty), 32'd1);
        pop = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_udf",   32'(underflow), 32'd0);
        check("clr_empty", 32'(empty), 32'd1);

        // Fill to full
        push = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push_data = 8'(8'h40 + i);
            step();
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_af",    32'(almost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
            check("fill_ae",    32'(almost_empty), (i + 1 <= 2) ? 32'd1 : 32'd0);
        end
        check("fill_full", 32'(full), 32'd1);
        push_data = 8'hEE;
        step();
        check("ovf_flag",  32'(overflow), ERR_EN);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_head",  32'(pop_data), 32'h40);

        // Push+pop while full: pop wins
        push_data = 8'hEF;
        pop       = 1'b1;
        step();
        check("fullpp_count", 32'(count), 32'd15);
        check("fullpp_full",  32'(full), 32'd0);
        check("fullpp_ovf",   32'(overflow), ERR_EN);
        check("fullpp_head",  32'(pop_data), 32'h41);
        push = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check("drain_data", 32'(pop_data), 32'(8'h41 + i));
            step();
        end
        check("drain_empty", 32'(empty), 32'd1);

        // Push+pop while empty: push wins
        push      = 1'b1;
        push_data = 8'h77;
        step();
        check("emptypp_count", 32'(count), 32'd1);
        check("emptypp_udf",   32'(underflow), ERR_EN);
        check("emptypp_data",  32'(pop_data), 32'h77);

        // Flush has priority over a concurrent push and pop
        clr = 1'b1;
        step();
        clr  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        check("clr_count", 32'(count), 32'd0);
        check("clr_empty2", 32'(empty), 32'd1);
        check("clr_ovf",   32'(overflow), 32'd0);
        check("clr_udf2",  32'(underflow), 32'd0);

        // Steady push+pop at count 5 across the pointer wrap
        push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_data = 8'(i);
            step();
        end
        check("wrap_pre_count", 32'(count), 32'd5);
        pop = 1'b1;
        for (int i = 0; i < 30; i++) begin
            push_data = 8'(5 + i);
            check("wrap_data", 32'(pop_data), 32'(i));
            step();
            check("wrap_count", 32'(count), 32'd5);
        end
        push = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("wrap_tail", 32'(pop_data), 32'(30 + i));
            step();
        end
        pop = 1'b0;
        check("wrap_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-stream
        push = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_data = 8'(8'h80 + i);
            step();
        end
        push = 1'b0;
        check("pre_rst_count", 32'(count), 32'd10);
        rst = 1'b0;
        #1;
        check("async_rst_empty", 32'(empty), 32'd1);
        check("async_rst_count", 32'(count), 32'd0);
        step();
        rst       = 1'b1;
        push      = 1'b1;
        push_data = 8'hA5;
        step();
        check("rerelease_edge1", 32'(count), 32'd0);
        step();
        push = 1'b0;
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_data",  32'(pop_data), 32'hA5);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sync_fifo
